// File: rtl/ecc_apb_sequencer.sv
// Purpose: APB master that turns one ECC command into the DATA_IN/CODEWORD_WIDTH/NOISE/CTRL write sequence, then waits for operation_done and returns the result.
// Latency: first SETUP one cycle after accept, two cycles per write, response the cycle after done/timeout/illegal; all outputs registered.
// Backpressure: cmd_ready only in IDLE; response held stable in RESP until rsp_ready. Optional macro ECC_SEQ_SKIP_WIDTH_EN skips repeated CODEWORD_WIDTH writes.
module ecc_apb_sequencer #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 15
) (
    input  logic                       clk,
    input  logic                       arstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_ctrl,
    input  logic [AMBA_WORD-1:0]       cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [AMBA_WORD-1:0]       cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic [1:0]                 rsp_status
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] CTRL_FULL    = 2'b10;
    localparam logic [1:0] CTRL_ILLEGAL = 2'b11;
    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_TIMEOUT   = 2'b01;
    localparam logic [1:0] ST_ILLEGAL   = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SEL_DATA, SEL_WIDTH, SEL_NOISE, SEL_CTRL} sel_t;

    state_t                 state_q, state_d;
    sel_t                   sel_q, sel_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [1:0]             ctrl_q, width_q;
    logic [AMBA_WORD-1:0]   data_q, noise_q;
    logic                   skip_q, skip_now, accept;
    logic                   cap_en;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic [1:0]             cap_err, cap_status;
    logic                   cmd_ready_d, rsp_valid_d, psel_d, penable_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_d;
    logic [AMBA_WORD-1:0]   pwdata_d;

    // Write order: DATA_IN, CODEWORD_WIDTH (unless skipped), NOISE (full channel only), CTRL.
    function automatic sel_t next_sel(input sel_t cur, input logic full, input logic skip);
        case (cur)
            SEL_DATA:  next_sel = skip ? (full ? SEL_NOISE : SEL_CTRL) : SEL_WIDTH;
            SEL_WIDTH: next_sel = full ? SEL_NOISE : SEL_CTRL;
            default:   next_sel = SEL_CTRL;
        endcase
    endfunction

    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input sel_t sel);
        case (sel)
            SEL_DATA:  reg_addr = AMBA_ADDR_WIDTH'(8'h04);
            SEL_WIDTH: reg_addr = AMBA_ADDR_WIDTH'(8'h08);
            SEL_NOISE: reg_addr = AMBA_ADDR_WIDTH'(8'h0C);
            default:   reg_addr = AMBA_ADDR_WIDTH'(8'h00);
        endcase
    endfunction

    assign accept  = cmd_valid && cmd_ready;
    assign cnt_inc = cnt_q + CW'(1);

`ifdef ECC_SEQ_SKIP_WIDTH_EN
    logic       shadow_vld;
    logic [1:0] shadow_w;

    assign skip_now = shadow_vld && (cmd_width == shadow_w);

    // Track the width most recently sent to the ECC block; illegal commands invalidate it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            shadow_vld <= 1'b0;
            shadow_w   <= 2'b00;
        end else if (accept) begin
            if (cmd_ctrl == CTRL_ILLEGAL) begin
                shadow_vld <= 1'b0;
            end else begin
                shadow_vld <= 1'b1;
                shadow_w   <= cmd_width;
            end
        end
    end
`else
    assign skip_now = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_DATA;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the command fields on accept so the write list is independent of later cmd_* activity.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ctrl_q  <= 2'b00;
            width_q <= 2'b00;
            data_q  <= '0;
            noise_q <= '0;
            skip_q  <= 1'b0;
        end else if (accept) begin
            ctrl_q  <= cmd_ctrl;
            width_q <= cmd_width;
            data_q  <= cmd_data;
            noise_q <= cmd_noise;
            skip_q  <= skip_now;
        end
    end

    // Next-state logic; done wins over a coinciding timeout.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        cap_en     = 1'b0;
        cap_status = ST_OK;
        cap_data   = '0;
        cap_err    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_ctrl == CTRL_ILLEGAL) begin
                        state_d    = S_RESP;
                        cap_en     = 1'b1;
                        cap_status = ST_ILLEGAL;
                    end else begin
                        state_d = S_SETUP;
                        sel_d   = SEL_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_q == SEL_CTRL) begin
                    if (operation_done) begin
                        state_d  = S_RESP;
                        cap_en   = 1'b1;
                        cap_data = data_out;
                        cap_err  = num_of_errors;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_SETUP;
                    sel_d   = next_sel(sel_q, ctrl_q == CTRL_FULL, skip_q);
                end
            end
            S_WAIT: begin
                if (operation_done) begin
                    state_d  = S_RESP;
                    cap_en   = 1'b1;
                    cap_data = data_out;
                    cap_err  = num_of_errors;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIM) begin
                        state_d    = S_RESP;
                        cap_en     = 1'b1;
                        cap_status = ST_TIMEOUT;
                    end
                end
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output can be registered without adding latency.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
        paddr_d     = '0;
        pwdata_d    = '0;
        if (psel_d) begin
            paddr_d = reg_addr(sel_d);
            case (sel_d)
                SEL_DATA:  pwdata_d = (state_q == S_IDLE) ? cmd_data : data_q;
                SEL_WIDTH: pwdata_d = AMBA_WORD'(width_q);
                SEL_NOISE: pwdata_d = noise_q;
                default:   pwdata_d = AMBA_WORD'(ctrl_q);
            endcase
        end
    end

    // Output registers; response fields only change when a new result is captured.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_data   <= '0;
            rsp_errors <= 2'b00;
            rsp_status <= 2'b00;
        end else begin
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= psel_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            if (cap_en) begin
                rsp_data   <= cap_data;
                rsp_errors <= cap_err;
                rsp_status <= cap_status;
            end
        end
    end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Purpose: directed bench for ecc_apb_sequencer with APB-write and response scoreboards.
// Latency: expected write cycles are derived from the accept cycle; response timing checked at fixed offsets.
// Backpressure: exercises rsp_ready low for several cycles and a mid-operation reset.
module tb_ecc_apb_sequencer;

    localparam int AW  = 32;
    localparam int ADW = 20;
    localparam int DW  = 8;
    localparam int TO  = 15;

    logic           clk = 1'b0;
    logic           arstn;
    logic           cmd_valid, cmd_ready;
    logic [1:0]     cmd_ctrl, cmd_width;
    logic [AW-1:0]  cmd_data, cmd_noise;
    logic [ADW-1:0] PADDR;
    logic           PSEL, PENABLE, PWRITE;
    logic [AW-1:0]  PWDATA;
    logic           operation_done;
    logic [DW-1:0]  data_out;
    logic [1:0]     num_of_errors;
    logic           rsp_valid, rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic [1:0]     rsp_errors, rsp_status;

    always #5 clk = ~clk;

    ecc_apb_sequencer #(
        .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .arstn(arstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
        .cmd_data(cmd_data), .cmd_width(cmd_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_errors(rsp_errors), .rsp_status(rsp_status)
    );

    typedef struct { logic [ADW-1:0] addr; logic [AW-1:0] data; int cyc; } wr_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] err; logic [1:0] status; } rsp_t;

    wr_t  wr_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic           prev_setup = 1'b0;
    logic [ADW-1:0] prev_addr  = '0;
    logic [AW-1:0]  prev_data  = '0;

`ifdef ECC_SEQ_SKIP_WIDTH_EN
    logic       m_sh_vld = 1'b0;
    logic [1:0] m_sh_w   = 2'b00;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [ADW-1:0] a, input logic [AW-1:0] d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        wr_q.push_back(w);
    endtask

    task automatic push_rsp(input logic [DW-1:0] d, input logic [1:0] e, input logic [1:0] s);
        rsp_t r;
        r.data = d; r.err = e; r.status = s;
        rsp_q.push_back(r);
    endtask

    // Drive one command at the current cycle (t0) and queue the writes it should produce.
    task automatic send_cmd(input logic [1:0] ctrl, input logic [AW-1:0] data,
                            input logic [1:0] width, input logic [AW-1:0] noise);
        int  n = 0;
        int  t0;
        bit  skip = 1'b0;
        t0 = cyc;
        check("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        if (ctrl != 2'b11) begin
`ifdef ECC_SEQ_SKIP_WIDTH_EN
            skip     = m_sh_vld && (m_sh_w == width);
            m_sh_vld = 1'b1;
            m_sh_w   = width;
`endif
            n++; push_wr(20'h04, data, t0 + 2 * n);
            if (!skip) begin n++; push_wr(20'h08, AW'(width), t0 + 2 * n); end
            if (ctrl == 2'b10) begin n++; push_wr(20'h0C, noise, t0 + 2 * n); end
            n++; push_wr(20'h00, AW'(ctrl), t0 + 2 * n);
        end else begin
`ifdef ECC_SEQ_SKIP_WIDTH_EN
            m_sh_vld = 1'b0;
`endif
        end
        cmd_valid = 1'b1; cmd_ctrl = ctrl; cmd_data = data; cmd_width = width; cmd_noise = noise;
        tick();
        cmd_valid = 1'b0; cmd_ctrl = 2'b00; cmd_data = '0; cmd_width = 2'b00; cmd_noise = '0;
    endtask

    // Encode command whose done is raised on the first WAIT_DONE cycle, wherever that lands.
    task automatic run_cmd(input logic [1:0] width, input logic [AW-1:0] data, input logic [DW-1:0] dout);
        bit found = 1'b0;
        push_rsp(dout, 2'd0, 2'd0);
        send_cmd(2'b00, data, width, '0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (PSEL && PENABLE && PADDR == 20'h0) found = 1'b1;
            tick();
        end
        check("ctrl_access_seen", 64'(found), 64'd1);
        operation_done = 1'b1; data_out = dout;
        tick();
        operation_done = 1'b0; data_out = '0;
        check("run_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
    endtask

    // Bus monitor: scoreboard every ACCESS, check SETUP->ACCESS pairing and the idle bus.
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (PSEL && PENABLE) begin
            check("access_follows_setup", {61'd0, prev_setup, prev_addr == PADDR, prev_data == PWDATA}, 64'd7);
            check("write_expected", 64'(wr_q.size() != 0), 64'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_addr", 64'(PADDR), 64'(w.addr));
                check("wr_data", 64'(PWDATA), 64'(w.data));
                check("wr_cycle", 64'(cyc), 64'(w.cyc));
                check("wr_pwrite", 64'(PWRITE), 64'd1);
            end
        end else if (!PSEL) begin
            check("idle_bus", 64'({PENABLE, PWRITE, PADDR, PWDATA}), 64'd0);
        end
        prev_setup = PSEL && !PENABLE;
        prev_addr  = PADDR;
        prev_data  = PWDATA;
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
            if (rsp_q.size() != 0) begin
                r = rsp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(r.data));
                check("rsp_errors", 64'(rsp_errors), 64'(r.err));
                check("rsp_status", 64'(rsp_status), 64'(r.status));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_ctrl = 2'b00; cmd_data = '0; cmd_width = 2'b00;
        cmd_noise = '0; operation_done = 1'b0; data_out = '0; num_of_errors = 2'b00; rsp_ready = 1'b1;
        repeat (2) tick();

        // Reset values.
        check("rst_ctrl_outs", 64'({PSEL, PENABLE, PWRITE, rsp_valid, cmd_ready}), 64'd1);
        check("rst_paddr_pwdata", 64'({PADDR, PWDATA}), 64'd0);
        check("rst_rsp_fields", 64'({rsp_data, rsp_errors, rsp_status}), 64'd0);
        arstn = 1'b1;
        repeat (2) tick();

        // Encode: done at t8, response at t9.
        push_rsp(8'hB3, 2'd0, 2'd0);
        send_cmd(2'b00, 32'h5A, 2'd0, 32'h0);
        repeat (7) tick();
        check("enc_no_rsp_before_done", 64'(rsp_valid), 64'd0);
        operation_done = 1'b1; data_out = 8'hB3; num_of_errors = 2'd0;
        tick();
        operation_done = 1'b0; data_out = '0;
        check("enc_rsp_t9", 64'({rsp_valid, rsp_data, rsp_errors, rsp_status}), 64'({1'b1, 8'hB3, 2'd0, 2'd0}));
        tick();
        check("enc_idle_after_hs", 64'({rsp_valid, cmd_ready}), 64'b01);
        check("enc_fields_kept", 64'(rsp_data), 64'hB3);

        // Full channel with a stray done during the writes, done in CTRL ACCESS, then backpressure.
        push_rsp(8'h3C, 2'd1, 2'd0);
        send_cmd(2'b10, 32'h3C, 2'd1, 32'h4);
        repeat (2) tick();
        operation_done = 1'b1; data_out = 8'hFF; num_of_errors = 2'd3;
        tick();
        operation_done = 1'b0; data_out = '0; num_of_errors = 2'd0;
        repeat (3) tick();
        rsp_ready = 1'b0;
        tick();
        check("full_ctrl_access_t8", 64'({PSEL, PENABLE, PADDR, PWDATA}), 64'({1'b1, 1'b1, 20'h0, 32'h2}));
        operation_done = 1'b1; data_out = 8'h3C; num_of_errors = 2'd1;
        tick();
        operation_done = 1'b0; data_out = 8'h99; num_of_errors = 2'd2;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({rsp_valid, cmd_ready, rsp_data, rsp_errors, rsp_status}),
                  64'({1'b1, 1'b0, 8'h3C, 2'd1, 2'd0}));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_released", 64'({rsp_valid, cmd_ready}), 64'b01);

        // Timeout: 15 WAIT_DONE cycles (t7..t21), response at t22 with zeroed fields.
        data_out = 8'hAA; num_of_errors = 2'd2;
        push_rsp(8'h00, 2'd0, 2'd1);
        send_cmd(2'b01, 32'h11, 2'd2, 32'h0);
        repeat (20) tick();
        check("to_still_waiting_t21", 64'({rsp_valid, PSEL}), 64'b00);
        tick();
        check("to_rsp_t22", 64'({rsp_valid, rsp_data, rsp_errors, rsp_status}), 64'({1'b1, 8'h0, 2'd0, 2'd1}));
        tick();
        data_out = '0; num_of_errors = 2'd0;

        // Illegal command: no APB traffic, response at t1.
        push_rsp(8'h00, 2'd0, 2'd2);
        send_cmd(2'b11, 32'hDEAD, 2'd1, 32'h55);
        check("ill_rsp_t1", 64'({rsp_valid, PSEL, rsp_data, rsp_errors, rsp_status}),
              64'({1'b1, 1'b0, 8'h0, 2'd0, 2'd2}));
        tick();
        check("ill_back_idle", 64'(cmd_ready), 64'd1);

        // Reset asserted during the NOISE SETUP cycle aborts everything.
        send_cmd(2'b10, 32'h77, 2'd3, 32'h8);
        repeat (4) tick();
        check("rst_noise_setup", 64'({PSEL, PENABLE, PADDR, PWDATA}), 64'({1'b1, 1'b0, 20'hC, 32'h8}));
        arstn = 1'b0;
        #1;
        check("rst_abort", 64'({PSEL, PENABLE, cmd_ready, rsp_valid}), 64'b0010);
        wr_q.delete();
`ifdef ECC_SEQ_SKIP_WIDTH_EN
        m_sh_vld = 1'b0;
`endif
        tick();
        arstn = 1'b1;
        operation_done = 1'b1;
        tick();
        operation_done = 1'b0;
        repeat (3) tick();
        check("rst_stays_idle", 64'({rsp_valid, cmd_ready, PSEL}), 64'b010);

        // Repeated width: skipped CODEWORD_WIDTH write only when the option is built in.
        run_cmd(2'd1, 32'h01, 8'h11);
        run_cmd(2'd1, 32'h02, 8'h22);
        run_cmd(2'd2, 32'h03, 8'h33);

        repeat (3) tick();
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
